// File: rtl/mux_ser_pkg.sv
// Shared types and constants for the parallel-to-serial controller and its bit selector.
package mux_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int WIDTH_DEF = 64;

    // The selector tree is two stages of 8:1 muxes, covering up to 64 inputs.
    localparam int LEAF_W = 8;
    localparam int TREE_W = LEAF_W * LEAF_W;

endpackage

// File: rtl/mux_serializer_ctrl_bit_select64.sv
// Combinational WIDTH:1 bit selector, built as two levels of 8:1 stages.
module bit_select64
    import mux_ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             sel_bit
);

    generate
        if (WIDTH <= TREE_W) begin : g_tree
            logic [TREE_W-1:0] data_pad;
            logic [5:0]        sel_pad;
            logic [LEAF_W-1:0] stage1;

            // Narrower words are zero-padded so the tree shape stays fixed.
            always_comb begin
                data_pad              = '0;
                data_pad[WIDTH-1:0]   = data;
                sel_pad               = '0;
                sel_pad[SEL_W-1:0]    = sel;
            end

            for (genvar gi = 0; gi < LEAF_W; gi++) begin : g_leaf
                logic [LEAF_W-1:0] group_bits;
                assign group_bits = data_pad[gi*LEAF_W +: LEAF_W];
                assign stage1[gi] = group_bits[sel_pad[2:0]];
            end

            assign sel_bit = stage1[sel_pad[5:3]];
        end else begin : g_flat
            assign sel_bit = data[sel];
        end
    endgenerate

endmodule

// File: rtl/mux_serializer_ctrl.sv
// Parallel-to-serial controller: captures a word and its length, then walks the
// bit selector from bit 0 upward, emitting one bit per accepted output beat.
module mux_serializer_ctrl
    import mux_ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] len_q, len_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             at_last;
    logic             sel_bit;

    bit_select64 #(
        .WIDTH (WIDTH)
    ) u_bit_select (
        .data    (data_q),
        .sel     (sel_q),
        .sel_bit (sel_bit)
    );

    // sel never passes len_q, so the counter cannot wrap.
    assign at_last = (sel_q == len_q);
    assign sel     = sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    len_d   = in_len;
                    sel_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (at_last) begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_bit   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = at_last;
                out_bit   = sel_bit;
            end
        endcase
    end

endmodule
